// File: rtl/driver_punte_h.sv
// Dual-channel H-bridge pin driver: shared packed-BCD PWM counter, commands
// latched at the period boundary, and a dead-time interlock on reversal.

module driver_punte_h_canal #(
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cnt,
  input  logic        boundary,
  input  logic [1:0]  dir,
  input  logic [11:0] duty,
  output logic        in1,
  output logic        in2,
  output logic        en,
  output logic        dead
);
  localparam logic [2:0] S_COAST = 3'd0;
  localparam logic [2:0] S_FWD   = 3'd1;
  localparam logic [2:0] S_REV   = 3'd2;
  localparam logic [2:0] S_BRAKE = 3'd3;
  localparam logic [2:0] S_DEAD  = 3'd4;

  logic [2:0]  state, pend, dir_st, target;
  logic [7:0]  dead_cnt;
  logic [11:0] duty_lat, duty_san;
  logic        en_pwm, reversal;

  always_comb begin
    dir_st = S_COAST;
    unique case (dir)
      2'b10:   dir_st = S_FWD;
      2'b01:   dir_st = S_REV;
      2'b00:   dir_st = S_BRAKE;
      default: dir_st = S_COAST;
    endcase
  end

  // Invalid BCD digits saturate at 9 so the binary compare stays monotonic.
  always_comb begin
    duty_san[3:0]  = (duty[3:0]  > 4'd9) ? 4'd9 : duty[3:0];
    duty_san[7:4]  = (duty[7:4]  > 4'd9) ? 4'd9 : duty[7:4];
    duty_san[11:8] = (duty[11:8] > 4'd9) ? 4'd9 : duty[11:8];
  end

  always_comb begin
    en_pwm   = (cnt < duty_lat);
    target   = boundary ? dir_st : pend;
    reversal = ((state == S_FWD) && (dir_st == S_REV)) ||
               ((state == S_REV) && (dir_st == S_FWD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_COAST;
      pend     <= S_COAST;
      dead_cnt <= '0;
      duty_lat <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      en       <= 1'b0;
      dead     <= 1'b0;
    end else begin
      in1  <= 1'b0;
      in2  <= 1'b0;
      en   <= 1'b0;
      dead <= 1'b0;
      case (state)
        S_FWD:   begin in1 <= 1'b1; en <= en_pwm; end
        S_REV:   begin in2 <= 1'b1; en <= en_pwm; end
        S_BRAKE: en <= 1'b1;
        S_DEAD:  dead <= 1'b1;
        default: ;
      endcase

      if (boundary) duty_lat <= duty_san;

      // Commands arriving during dead time only retarget; the timer always completes.
      if (state == S_DEAD) begin
        if (boundary) pend <= dir_st;
        if (dead_cnt <= 8'd1) state <= target;
        else                  dead_cnt <= dead_cnt - 8'd1;
      end else if (boundary) begin
        if (reversal) begin
          state    <= S_DEAD;
          pend     <= dir_st;
          dead_cnt <= 8'(DEAD_CYCLES);
        end else begin
          state <= dir_st;
        end
      end
    end
  end
endmodule

module driver_punte_h #(
  parameter int unsigned DEAD_CYCLES = 16,
  parameter logic [11:0] PWM_TOP     = 12'h999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        in1_A,
  output logic        in2_A,
  output logic        en_A,
  output logic        in1_B,
  output logic        in2_B,
  output logic        en_B,
  output logic        tact_pwm,
  output logic [1:0]  dead_activ
);
  logic [11:0] cnt, cnt_nxt;
  logic        boundary, dead_a, dead_b;

  assign boundary   = (cnt == PWM_TOP);
  assign dead_activ = {dead_b, dead_a};

  always_comb begin
    cnt_nxt = cnt;
    if (cnt[3:0] != 4'd9) begin
      cnt_nxt[3:0] = cnt[3:0] + 4'd1;
    end else begin
      cnt_nxt[3:0] = 4'd0;
      if (cnt[7:4] != 4'd9) begin
        cnt_nxt[7:4] = cnt[7:4] + 4'd1;
      end else begin
        cnt_nxt[7:4]  = 4'd0;
        cnt_nxt[11:8] = (cnt[11:8] != 4'd9) ? cnt[11:8] + 4'd1 : 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tact_pwm <= 1'b0;
    end else begin
      cnt      <= boundary ? '0 : cnt_nxt;
      tact_pwm <= (cnt == '0);
    end
  end

  driver_punte_h_canal #(.DEAD_CYCLES(DEAD_CYCLES)) u_a (
    .clk(clk), .rst(rst), .cnt(cnt), .boundary(boundary),
    .dir(directie_driverA), .duty(factor_dc_driverA),
    .in1(in1_A), .in2(in2_A), .en(en_A), .dead(dead_a)
  );

  driver_punte_h_canal #(.DEAD_CYCLES(DEAD_CYCLES)) u_b (
    .clk(clk), .rst(rst), .cnt(cnt), .boundary(boundary),
    .dir(directie_driverB), .duty(factor_dc_driverB),
    .in1(in1_B), .in2(in2_B), .en(en_B), .dead(dead_b)
  );
endmodule

// File: tb/tb_driver_punte_h.sv
// Scoreboard bench for driver_punte_h: a decimal period/dead-time model
// predicts every registered output; a negedge monitor compares.

module tb_driver_punte_h;
  localparam int PERIOD = 1000;
  localparam int DEAD   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dir_a = 2'b11, dir_b = 2'b11;
  logic [11:0] duty_a = '0, duty_b = '0;
  logic        in1_A, in2_A, en_A, in1_B, in2_B, en_B, tact_pwm;
  logic [1:0]  dead_activ;

  int checks = 0;
  int failures = 0;

  typedef enum int {M_COAST, M_FWD, M_REV, M_BRAKE, M_DEAD} mstate_t;
  mstate_t m_st[2], m_pend[2];
  int      m_left[2], m_duty[2];
  int      m_pos = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  driver_punte_h dut (
    .clk(clk), .rst(rst),
    .directie_driverA(dir_a), .directie_driverB(dir_b),
    .factor_dc_driverA(duty_a), .factor_dc_driverB(duty_b),
    .in1_A(in1_A), .in2_A(in2_A), .en_A(en_A),
    .in1_B(in1_B), .in2_B(in2_B), .en_B(en_B),
    .tact_pwm(tact_pwm), .dead_activ(dead_activ)
  );

  function automatic int bcd_val(input logic [11:0] d);
    int h, t, u;
    h = (d[11:8] > 4'd9) ? 9 : int'(d[11:8]);
    t = (d[7:4]  > 4'd9) ? 9 : int'(d[7:4]);
    u = (d[3:0]  > 4'd9) ? 9 : int'(d[3:0]);
    return h * 100 + t * 10 + u;
  endfunction

  function automatic mstate_t decode(input logic [1:0] d);
    case (d)
      2'b10:   return M_FWD;
      2'b01:   return M_REV;
      2'b00:   return M_BRAKE;
      default: return M_COAST;
    endcase
  endfunction

  // {in1, in2, en} of a channel while sitting in state s at period position pos
  function automatic logic [2:0] pins(input mstate_t s, input int pos, input int duty);
    case (s)
      M_FWD:   return {1'b1, 1'b0, pos < duty};
      M_REV:   return {1'b0, 1'b1, pos < duty};
      M_BRAKE: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0;
    for (int c = 0; c < 2; c++) begin
      m_st[c] = M_COAST; m_pend[c] = M_COAST; m_left[c] = 0; m_duty[c] = 0;
    end
  endtask

  initial model_reset();

  // Reference model: predicts the outputs that appear after each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      logic [8:0] e;
      mstate_t nd;
      int ndu;
      e = {m_pos == 0, m_st[1] == M_DEAD, m_st[0] == M_DEAD,
           pins(m_st[0], m_pos, m_duty[0]), pins(m_st[1], m_pos, m_duty[1])};
      sb.push_back(e);
      for (int c = 0; c < 2; c++) begin
        nd  = decode(c == 0 ? dir_a : dir_b);
        ndu = bcd_val(c == 0 ? duty_a : duty_b);
        if (m_st[c] == M_DEAD) begin
          m_left[c]--;
          if (m_pos == PERIOD - 1) m_pend[c] = nd;
          if (m_left[c] == 0) m_st[c] = m_pend[c];
        end else if (m_pos == PERIOD - 1) begin
          if ((m_st[c] == M_FWD && nd == M_REV) || (m_st[c] == M_REV && nd == M_FWD)) begin
            m_st[c] = M_DEAD; m_pend[c] = nd; m_left[c] = DEAD;
          end else begin
            m_st[c] = nd;
          end
        end
        if (m_pos == PERIOD - 1) m_duty[c] = ndu;
      end
      m_pos = (m_pos + 1) % PERIOD;
    end
  end

  function automatic logic [8:0] dut_vec();
    return {tact_pwm, dead_activ, in1_A, in2_A, en_A, in1_B, in2_B, en_B};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      checks++;
      if (dut_vec() !== 9'b0) begin
        failures++;
        $display("FAIL reset_outputs t=%0t got=%b exp=%b", $time, dut_vec(), 9'b0);
      end
    end else if (sb.size() > 0) begin
      logic [8:0] e;
      e = sb.pop_front();
      checks++;
      if (dut_vec() !== e) begin
        failures++;
        $display("FAIL outputs t=%0t pos=%0d got=%b exp=%b", $time, m_pos, dut_vec(), e);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (m_pos != p && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (m_pos != p) begin
      failures++;
      $display("FAIL wait_pos got=%0d exp=%0d", m_pos, p);
    end
  endtask

  function automatic logic [11:0] rand_duty();
    case ($urandom_range(0, 3))
      0:       return 12'h000;
      1:       return 12'h999;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    int k;
    cycles(3);
    dir_a = 2'b10; dir_b = 2'b10; duty_a = 12'h500; duty_b = 12'h500;
    #1 rst = 1'b0;
    cycles(2 * PERIOD + 50);

    duty_a = 12'h999;
    wait_pos(0);
    wait_pos(300);
    dir_a = 2'b01;
    cycles(PERIOD + 100);

    duty_a = 12'h000; duty_b = 12'h9A5;
    cycles(2 * PERIOD);
    dir_a = 2'b00; dir_b = 2'b11;
    cycles(2 * PERIOD);

    for (int i = 0; i < 12; i++) begin
      cycles($urandom_range(1, 1900));
      if ($urandom_range(0, 1) == 1) dir_a = 2'($urandom);
      if ($urandom_range(0, 1) == 1) dir_b = 2'($urandom);
      duty_a = rand_duty();
      duty_b = rand_duty();
    end
    cycles(PERIOD);

    // reversal on both channels, then reset five clocks into the dead time
    dir_a = 2'b10; dir_b = 2'b10; duty_a = 12'h700; duty_b = 12'h250;
    cycles(PERIOD + 10);
    dir_a = 2'b01; dir_b = 2'b01;
    k = 0;
    while (m_st[0] != M_DEAD && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (m_st[0] != M_DEAD) begin
      failures++;
      $display("FAIL dead_entry got=%0d exp=%0d", m_st[0], M_DEAD);
    end
    cycles(5);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 9'b0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", dut_vec(), 9'b0);
    end
    cycles(3);
    dir_a = 2'b10; dir_b = 2'b00;
    #1 rst = 1'b0;
    cycles(2 * PERIOD + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/driver_punte_h.md
Name: driver_punte_h

Overview:
- Dual-channel H-bridge driver stage that consumes the motion-logic outputs (per-channel 2-bit direction code plus 12-bit packed-BCD duty factor).
- Produces glitch-free IN1/IN2/EN pin signals for drivers A and B.
- Contains a shared 3-digit BCD PWM counter, period-boundary latching of commands, and a dead-time state machine on direction reversal.
- Sits between the motion logic and the physical motor driver pins.

Parameters:
- DEAD_CYCLES, 16: clocks with both bridge sides off on a forward<->reverse reversal (1..255).
- PWM_TOP, 12'h999: packed-BCD terminal count; PWM period = PWM_TOP+1 decimal clocks (default 1000).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- directie_driverA  in  2  channel A command: 10 forward, 01 reverse, 00 brake, 11 coast
- directie_driverB  in  2  channel B command, same encoding
- factor_dc_driverA  in  12  channel A duty, packed BCD 000..999
- factor_dc_driverB  in  12  channel B duty, packed BCD 000..999
- in1_A, in2_A, en_A  out  1 each  channel A bridge pins
- in1_B, in2_B, en_B  out  1 each  channel B bridge pins
- tact_pwm  out  1  one-clock pulse on the cycle the counter wraps to 000
- dead_activ  out  2  bit0 = A in DEAD, bit1 = B in DEAD

Behaviour:
- Reset (async assert, sync release):
  - counter = 000; both channels in COAST.
  - All in1/in2/en = 0; tact_pwm = 0; dead_activ = 00; latched duty = 000.
- PWM counter:
  - BCD increment, per-digit carry at 9; 000..PWM_TOP, then wraps to 000.
  - tact_pwm = 1 on the cycle the counter equals 000 (after reset release, the first 000 also pulses).
- Duty sanitising: each input BCD digit > 9 is clamped to 9 before latching.
- Comparison: packed-BCD magnitude equals binary comparison of the 12-bit vector.
- Command latching:
  - Direction and duty are sampled only on the cycle the counter is at PWM_TOP.
  - They take effect from counter 000.
  - Mid-period input changes are ignored until the next boundary.
- Per-channel FSM states: COAST, FWD, REV, BRAKE, DEAD.
  - Transitions are evaluated at the period boundary from the latched direction.
  - FWD->REV or REV->FWD go to DEAD; DEAD loads a down-counter with DEAD_CYCLES.
  - DEAD decrements each clock; at 0 it enters the pending direction.
  - If the next period starts a new cycle, the remaining period is simply shortened. The DEAD exit is not boundary-aligned; PWM resumes mid-period against the current counter.
  - All other transitions are direct.
  - A new command arriving while in DEAD updates the pending target. A reversal back to the original direction still completes the dead time.
- Pin mapping (en_pwm = counter < latched duty):
  - FWD: in1=1, in2=0, en=en_pwm
  - REV: in1=0, in2=1, en=en_pwm
  - BRAKE: in1=0, in2=0, en=1
  - COAST: in1=0, in2=0, en=0
  - DEAD: all 0, dead_activ bit = 1
- Duty edge values:
  - 000 gives en never high in FWD/REV.
  - 999 gives en high for 999 of 1000 clocks.
- All pin outputs are registered: one clock after the counter/state that produced them. Never in1=in2=1.
- Both channels are fully independent except for the shared counter. Simultaneous reversal on A and B runs both DEAD timers in parallel.
- Reset asserted mid-DEAD or mid-period aborts immediately to the reset state.

Test Plan:
- Reset release, both commands 10, duty 12'h500 -> from first period, en_A/en_B high for exactly 500 clocks of 1000; in1=1, in2=0; tact_pwm every 1000 clocks.
- A forward duty 12'h999, switch to 01 at counter 12'h300 -> no pin change until wrap. Then DEAD for 16 clocks (all A pins 0, dead_activ=01), then in2_A=1 with PWM resuming. B unaffected.
- Duty 12'h000 and 12'h999 -> en never high; en high 999/1000 clocks.
- Duty input 12'h9A5 -> latched as 12'h995, en high 995 clocks.
- Command 00 -> en=1, in1=in2=0 from next period; command 11 -> all 0.
- Assert rst during DEAD at clock 5 -> all outputs 0 asynchronously. After release, COAST until the first boundary latches a new command.
